// File: rtl/mem_port_arbiter.sv
// Two-way memory port arbiter: fixed D-side priority with an I-side starvation guard.
// The winner's request is latched at grant and held until the downstream response completes.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned DATA_W       = 64
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                i_valid,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_addr_ok,
    output logic                i_data_ok,
    output logic [31:0]         i_data,

    input  logic                d_valid,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [2:0]          d_size,
    input  logic [DATA_W/8-1:0] d_strobe,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_addr_ok,
    output logic                d_data_ok,
    output logic [DATA_W-1:0]   d_data,

    output logic                m_valid,
    output logic                m_is_write,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [2:0]          m_size,
    output logic [DATA_W/8-1:0] m_strobe,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_addr_ok,
    input  logic                m_data_ok,
    input  logic [DATA_W-1:0]   m_data
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   starve_cnt;
    logic [CNT_W-1:0]   starve_cnt_nxt;
    logic               starved;

    // I-side has waited through enough D-grants to win the next arbitration.
    assign starved = i_valid && (starve_cnt >= CNT_W'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        i_addr_ok      = 1'b0;
        i_data_ok      = 1'b0;
        d_addr_ok      = 1'b0;
        d_data_ok      = 1'b0;
        case (state)
            IDLE: begin
                if (d_valid && !starved) begin
                    state_nxt = GRANT_D;
                    if (i_valid && (starve_cnt != {CNT_W{1'b1}}))
                        starve_cnt_nxt = starve_cnt + CNT_W'(1);
                end else if (i_valid) begin
                    state_nxt      = GRANT_I;
                    starve_cnt_nxt = '0;
                end
            end
            GRANT_I: begin
                i_addr_ok = m_addr_ok;
                i_data_ok = m_data_ok;
                if (m_data_ok)
                    state_nxt = IDLE;
            end
            GRANT_D: begin
                d_addr_ok = m_addr_ok;
                d_data_ok = m_data_ok;
                if (m_data_ok)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields captured only on the IDLE->GRANT edge so they stay stable for the grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid    <= 1'b0;
            m_is_write <= 1'b0;
            m_addr     <= '0;
            m_size     <= '0;
            m_strobe   <= '0;
            m_wdata    <= '0;
        end else begin
            m_valid <= (state_nxt != IDLE);
            if (state == IDLE && state_nxt == GRANT_D) begin
                m_is_write <= |d_strobe;
                m_addr     <= d_addr;
                m_size     <= d_size;
                m_strobe   <= d_strobe;
                m_wdata    <= d_wdata;
            end else if (state == IDLE && state_nxt == GRANT_I) begin
                m_is_write <= 1'b0;
                m_addr     <= i_addr;
                m_size     <= 3'b010;
                m_strobe   <= STRB_W'(0);
                m_wdata    <= DATA_W'(0);
            end
        end
    end

    assign i_data = m_data[31:0];
    assign d_data = m_data;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single downstream memory port between the instruction-fetch requester (I-side) and the memory-stage requester (D-side) of the pipelined core. The D-side gets fixed priority, with a starvation counter that forces an I-side grant after a bounded run of D-side grants. The request fields are latched at grant and the port is held until the downstream response completes. The block sits between the core's ibus/dbus and the external memory bus.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive D-grants, with I-side waiting, that force the next grant to I-side (legal range 1..15).
- ADDR_W, 64: address width.
- DATA_W, 64: data width.

Ports:
- clk  in  1  the single clock.
- reset  in  1  synchronous, active-high.
- i_valid  in  1  I-side request valid; held until i_data_ok.
- i_addr  in  ADDR_W  I-side address; read only.
- i_addr_ok  out  1  I-side address accepted.
- i_data_ok  out  1  I-side data returned.
- i_data  out  32  I-side instruction, equal to m_data[31:0].
- d_valid  in  1  D-side request valid; held until d_data_ok.
- d_addr  in  ADDR_W  D-side address.
- d_size  in  3  D-side access size code.
- d_strobe  in  DATA_W/8  D-side byte strobe; nonzero means write.
- d_wdata  in  DATA_W  D-side write data.
- d_addr_ok  out  1  D-side address accepted.
- d_data_ok  out  1  D-side data returned.
- d_data  out  DATA_W  D-side read data.
- m_valid  out  1  downstream request valid.
- m_is_write  out  1  downstream write.
- m_addr  out  ADDR_W  downstream address.
- m_size  out  3  downstream size code.
- m_strobe  out  DATA_W/8  downstream strobe.
- m_wdata  out  DATA_W  downstream write data.
- m_addr_ok  in  1  downstream address accepted.
- m_data_ok  in  1  downstream transaction complete; read data valid.
- m_data  in  DATA_W  downstream read data.

## Operation
- States are IDLE, GRANT_I and GRANT_D, held in a registered state machine.
- IDLE arbitration, evaluated each cycle:
  - d_valid && !(i_valid && starve_cnt >= STARVE_LIMIT) → GRANT_D.
  - Otherwise, i_valid → GRANT_I.
  - Otherwise, stay in IDLE.
- On the IDLE→GRANT transition, the winner's request fields are latched into m_* registers.
  - I-side grants use size 3'b010, strobe 0, m_is_write 0 and wdata 0.
  - D-side grants set m_is_write = |d_strobe.
- In GRANT_x:
  - m_valid is 1 and m_* are driven from the latched registers.
  - x_addr_ok = m_addr_ok and x_data_ok = m_data_ok, combinationally.
  - The other side's ok outputs are 0.
- GRANT_x → IDLE on the cycle m_data_ok=1. No back-to-back grant is made in that same cycle.
- starve_cnt is 4 bits.
  - It increments, saturating at 15, on each IDLE→GRANT_D transition where i_valid=1.
  - It clears to 0 on each IDLE→GRANT_I transition.
  - It is otherwise held.
- If the granted requester drops valid before data_ok (protocol violation or flush), the arbiter still completes the latched transaction. The data_ok pulse is still driven to that side and is ignored upstream.
- i_data and d_data are combinational copies of m_data (i_data = m_data[31:0]) and are meaningful only when the corresponding data_ok is 1.

## Timing
- Reset values:
  - State is IDLE and starve_cnt is 0.
  - m_valid, m_is_write, m_addr, m_size, m_strobe and m_wdata are 0.
  - All *_addr_ok and *_data_ok outputs are 0.
- Reset asserted mid-transaction forces IDLE at the next edge. m_valid=0 from that edge on, and the outstanding downstream response is dropped.
- Arbitration latency is 1 cycle: a request arriving in IDLE at cycle t gives m_valid=1 at cycle t+1.
- Completion:
  - m_data_ok at cycle k gives x_data_ok at cycle k, with 0 added latency.
  - State is IDLE at k+1.
  - The earliest next m_valid is at k+2.
- Minimum turnaround is 3 cycles per transaction with a 1-cycle downstream.
- m_addr_ok and m_data_ok may be asserted in the same cycle; both pass through, and completion follows the m_data_ok rule.
- m_data_ok while in IDLE is ignored and produces no upstream pulse.
- m_* outputs are stable for the whole GRANT state regardless of changes on the upstream inputs.

## Test plan
- Reset check: hold reset for 3 cycles with i_valid=d_valid=1 → m_valid=0, all ok outputs 0 and starve_cnt=0. After release, m_valid=1 with m_addr=d_addr one cycle later.
- Single I-read: i_valid=1, i_addr=0x8000_0000, and memory answers m_data_ok 2 cycles after m_valid with m_data=0x0000_0000_0013_0513.
  - m_addr=0x8000_0000, m_is_write=0.
  - i_data_ok pulses one cycle with i_data=0x0013_0513.
  - d_* ok outputs stay 0.
- D-write latch: d_valid=1, addr=0x8000_1000, strobe=0xFF, wdata=0xDEAD_BEEF. Change d_addr to 0x0 after grant → m_addr stays 0x8000_1000 and m_is_write=1 until m_data_ok.
- Starvation, STARVE_LIMIT=4: hold i_valid and d_valid high continuously → grant order D,D,D,D,I,D,D,D,D,I, with starve_cnt reaching 4 then clearing.
- Reset mid-transaction: assert reset while in GRANT_D before m_data_ok, then inject m_data_ok one cycle after reset → no d_data_ok pulse, and state is IDLE.
- Requester drop: in GRANT_I, deassert i_valid, then m_data_ok arrives → i_data_ok still pulses, and state returns to IDLE the next cycle.
